// File: rtl/rr_mux21_arbiter_if.sv
// Stream bundle for rr_mux21_arbiter: two valid/ready inputs, the sel output and the registered f output.
// The i0_last/i1_last packet markers exist only when BURST_LOCK_EN is defined.
interface rr_mux21_arbiter_if #(
  parameter int W = 8
);
  logic [W-1:0] i0;
  logic         i0_valid;
  logic         i0_ready;
  logic [W-1:0] i1;
  logic         i1_valid;
  logic         i1_ready;
  logic         sel;
  logic [W-1:0] f;
  logic         f_valid;
  logic         f_ready;
`ifdef BURST_LOCK_EN
  logic         i0_last;
  logic         i1_last;

  modport slave (
    input  i0, i0_valid, i0_last, i1, i1_valid, i1_last, f_ready,
    output i0_ready, i1_ready, sel, f, f_valid
  );
  modport master (
    output i0, i0_valid, i0_last, i1, i1_valid, i1_last, f_ready,
    input  i0_ready, i1_ready, sel, f, f_valid
  );
`else
  modport slave (
    input  i0, i0_valid, i1, i1_valid, f_ready,
    output i0_ready, i1_ready, sel, f, f_valid
  );
  modport master (
    output i0, i0_valid, i1, i1_valid, f_ready,
    input  i0_ready, i1_ready, sel, f, f_valid
  );
`endif
endinterface

// File: rtl/rr_mux21_arbiter.sv
// Round-robin 2:1 stream arbiter with a one-deep registered output stage.
// Optional packet locking (hold the grant until a last beat) is enabled with BURST_LOCK_EN.
module rr_mux21_arbiter #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_mux21_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    LOCK0  = 2'd1,
    LOCK1  = 2'd2
  } state_t;

  state_t       state_r;
  state_t       next_state_s;
  logic         prio_r;
  logic [W-1:0] f_r;
  logic         f_valid_r;
  logic         grant_s;
  logic         granted_valid_s;
  logic         load_en_s;
  logic         accept_s;

  // Grant selection: a lone valid stream wins, otherwise the priority pointer decides
  always_comb begin
    grant_s = prio_r;
    case (state_r)
      UNLOCK: begin
        if (bus.i0_valid && !bus.i1_valid) begin
          grant_s = 1'b0;
        end else if (!bus.i0_valid && bus.i1_valid) begin
          grant_s = 1'b1;
        end else begin
          grant_s = prio_r;
        end
      end
      LOCK0:   grant_s = 1'b0;
      LOCK1:   grant_s = 1'b1;
      default: grant_s = prio_r;
    endcase
  end

  // Load enable and acceptance; pass-through lets a draining word be replaced in the same cycle
  always_comb begin
    load_en_s       = !f_valid_r || bus.f_ready;
    granted_valid_s = grant_s ? bus.i1_valid : bus.i0_valid;
    accept_s        = load_en_s && rst_n && granted_valid_s;
  end

  assign bus.sel      = grant_s;
  assign bus.i0_ready = load_en_s & ~grant_s & rst_n;
  assign bus.i1_ready = load_en_s & grant_s & rst_n;
  assign bus.f        = f_r;
  assign bus.f_valid  = f_valid_r;

`ifdef BURST_LOCK_EN
  logic granted_last_s;

  // Packet lock: stay on a stream from its first non-last beat until its last beat
  always_comb begin
    next_state_s   = state_r;
    granted_last_s = grant_s ? bus.i1_last : bus.i0_last;
    case (state_r)
      UNLOCK: begin
        if (accept_s && !granted_last_s) begin
          next_state_s = grant_s ? LOCK1 : LOCK0;
        end else begin
          next_state_s = UNLOCK;
        end
      end
      LOCK0, LOCK1: begin
        if (accept_s && granted_last_s) begin
          next_state_s = UNLOCK;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = UNLOCK;
    endcase
  end
`else
  // Without packet locking the arbiter never leaves UNLOCK
  always_comb begin
    next_state_s = UNLOCK;
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= UNLOCK;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Output register and priority pointer; the pointer only moves on an accepted beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_r       <= {W{1'b0}};
      f_valid_r <= 1'b0;
      prio_r    <= 1'b0;
    end else if (load_en_s) begin
      if (granted_valid_s) begin
        f_r       <= grant_s ? bus.i1 : bus.i0;
        f_valid_r <= 1'b1;
        prio_r    <= ~grant_s;
      end else begin
        f_valid_r <= 1'b0;
      end
    end else begin
      f_r       <= f_r;
      f_valid_r <= f_valid_r;
      prio_r    <= prio_r;
    end
  end

endmodule
